seg7_scan: RTL

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It consumes the eight static active-low segment patterns produced by the GPIO APB peripheral (gpio_seg_0..7) and drives them onto one shared segment bus plus eight active-low digit selects. It steps one digit per slot, with a blanking gap between slots to suppress ghosting. It sits between the GPIO peripheral and the board pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and FSM state type for the seven-segment scanner.
//   NUM_DIGITS - number of multiplexed digits
//   SEG_BLANK  - all segments off (active-low bus)
//   DIG_OFF    - all digit selects off (active-low)
//   state_t    - slot FSM state: BLANK gap, then SHOW
package seg7_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] DIG_OFF    = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit common-anode display.
// Each digit gets a slot of SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot are dark to suppress ghosting, the remainder show the pattern that was
// captured when the slot entered SHOW.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_seg_0..7    active-low segment patterns {a,b,c,d,e,f,g,dp}
//   i_digit_en    per-digit enable, low keeps that digit dark
//   o_seg_out     shared active-low segment bus (registered)
//   o_dig_sel     active-low digit selects, at most one low (registered)
//   o_scan_idx    digit index of the current slot
//   o_frame_tick  one-cycle pulse at the start of each new frame
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_seg_0,
    input  logic [7:0] i_seg_1,
    input  logic [7:0] i_seg_2,
    input  logic [7:0] i_seg_3,
    input  logic [7:0] i_seg_4,
    input  logic [7:0] i_seg_5,
    input  logic [7:0] i_seg_6,
    input  logic [7:0] i_seg_7,
    input  logic [7:0] i_digit_en,
    output logic [7:0] o_seg_out,
    output logic [7:0] o_dig_sel,
    output logic [2:0] o_scan_idx,
    output logic       o_frame_tick
);

    localparam logic [15:0] CNT_MAX  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_AT = 16'(BLANK_CYC);
    // Without blanking the slot FSM never leaves SHOW.
    localparam state_t      ST_RST   = (BLANK_CYC == 0) ? SHOW : BLANK;

    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    state_t      r_state;
    logic [7:0]  r_cap_seg;
    logic        r_cap_en;
    logic [7:0]  r_seg_out;
    logic [7:0]  r_dig_sel;
    logic        r_frame_tick;

    logic        w_wrap;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_idx_nxt;
    state_t      w_state_nxt;
    logic        w_capture;
    logic [7:0]  w_segs [NUM_DIGITS];
    logic [7:0]  w_seg_in;
    logic        w_en_in;
    logic [7:0]  w_cap_seg_nxt;
    logic        w_cap_en_nxt;
    logic [7:0]  w_seg_nxt;
    logic [7:0]  w_dig_nxt;
    logic [7:0]  w_one;

    assign w_segs[0] = i_seg_0;
    assign w_segs[1] = i_seg_1;
    assign w_segs[2] = i_seg_2;
    assign w_segs[3] = i_seg_3;
    assign w_segs[4] = i_seg_4;
    assign w_segs[5] = i_seg_5;
    assign w_segs[6] = i_seg_6;
    assign w_segs[7] = i_seg_7;

    assign w_wrap    = (r_cnt == CNT_MAX);
    assign w_cnt_nxt = w_wrap ? 16'd0 : r_cnt + 16'd1;
    assign w_idx_nxt = w_wrap ? r_idx + 3'd1 : r_idx;

    // The mux follows the index of the slot being entered, so a capture on
    // the wrap edge (no blanking) already picks up the new digit.
    assign w_seg_in  = w_segs[w_idx_nxt];
    assign w_en_in   = i_digit_en[w_idx_nxt];

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_wrap) begin
            w_state_nxt = (BLANK_CYC == 0) ? SHOW : BLANK;
        end else if (r_state == BLANK && w_cnt_nxt == BLANK_AT) begin
            w_state_nxt = SHOW;
        end
    end

    // Output logic: computed from next-cycle values and then registered, so
    // the outputs visible at cnt = k reflect state(k) with no input-to-output
    // combinational path.
    always_comb begin
        w_capture     = (w_state_nxt == SHOW) && ((r_state == BLANK) || w_wrap);
        w_cap_seg_nxt = w_capture ? w_seg_in : r_cap_seg;
        w_cap_en_nxt  = w_capture ? w_en_in  : r_cap_en;
        w_one         = 8'd1;
        w_seg_nxt     = SEG_BLANK;
        w_dig_nxt     = DIG_OFF;
        if (w_state_nxt == SHOW) begin
            w_seg_nxt = w_cap_seg_nxt;
            if (w_cap_en_nxt) begin
                w_dig_nxt = ~(w_one << w_idx_nxt);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt        <= 16'd0;
            r_idx        <= 3'd0;
            r_cap_seg    <= SEG_BLANK;
            r_cap_en     <= 1'b0;
            r_seg_out    <= SEG_BLANK;
            r_dig_sel    <= DIG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_cap_seg    <= w_cap_seg_nxt;
            r_cap_en     <= w_cap_en_nxt;
            r_seg_out    <= w_seg_nxt;
            r_dig_sel    <= w_dig_nxt;
            // Only a 7 -> 0 wrap starts a frame; the slot after reset does not.
            r_frame_tick <= w_wrap && (r_idx == 3'd7);
        end
    end

    assign o_seg_out    = r_seg_out;
    assign o_dig_sel    = r_dig_sel;
    assign o_scan_idx   = r_idx;
    assign o_frame_tick = r_frame_tick;

endmodule
